// File: rtl/mips_pkg.sv
// Shared constants for the MIPS execute stage: ALU opcodes, forward selects,
// default widths and the EX/MEM control bundle.
package mips_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [1:0] FWD_ID  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
    } ctrl_t;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX-to-EX/MEM bus of the execute stage. The master side is the pipeline
// front end (ID/EX, forwarding and hazard logic); the slave side is ex_stage.
interface ex_stage_if
    import mips_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
);
    logic                  i_stall;
    logic                  i_flush;
    logic                  i_valid_EX;
    logic [DATA_W-1:0]     i_rs_data_EX;
    logic [DATA_W-1:0]     i_rt_data_EX;
    logic [DATA_W-1:0]     i_imm_EX;
    logic [4:0]            i_shamt_EX;
    logic                  i_shift_var_EX;
    logic [3:0]            i_alu_op_EX;
    logic                  i_alu_src_EX;
    logic [REG_ADDR_W-1:0] i_rd_EX;
    logic                  i_regwrite_EX;
    logic                  i_memread_EX;
    logic                  i_memwrite_EX;
    logic                  i_memtoreg_EX;
    logic [1:0]            i_forward_a;
    logic [1:0]            i_forward_b;
    logic [DATA_W-1:0]     i_fwd_mem_data;
    logic [DATA_W-1:0]     i_fwd_wb_data;

    logic [DATA_W-1:0]     o_alu_result_MEM;
    logic [DATA_W-1:0]     o_store_data_MEM;
    logic [REG_ADDR_W-1:0] o_rd_MEM;
    logic                  o_regwrite_MEM;
    logic                  o_memread_MEM;
    logic                  o_memwrite_MEM;
    logic                  o_memtoreg_MEM;
    logic                  o_valid_MEM;
    logic                  o_zero_EX;

    modport master (
        output i_stall, i_flush, i_valid_EX, i_rs_data_EX, i_rt_data_EX, i_imm_EX,
               i_shamt_EX, i_shift_var_EX, i_alu_op_EX, i_alu_src_EX, i_rd_EX,
               i_regwrite_EX, i_memread_EX, i_memwrite_EX, i_memtoreg_EX,
               i_forward_a, i_forward_b, i_fwd_mem_data, i_fwd_wb_data,
        input  o_alu_result_MEM, o_store_data_MEM, o_rd_MEM, o_regwrite_MEM,
               o_memread_MEM, o_memwrite_MEM, o_memtoreg_MEM, o_valid_MEM, o_zero_EX
    );

    modport slave (
        input  i_stall, i_flush, i_valid_EX, i_rs_data_EX, i_rt_data_EX, i_imm_EX,
               i_shamt_EX, i_shift_var_EX, i_alu_op_EX, i_alu_src_EX, i_rd_EX,
               i_regwrite_EX, i_memread_EX, i_memwrite_EX, i_memtoreg_EX,
               i_forward_a, i_forward_b, i_fwd_mem_data, i_fwd_wb_data,
        output o_alu_result_MEM, o_store_data_MEM, o_rd_MEM, o_regwrite_MEM,
               o_memread_MEM, o_memwrite_MEM, o_memtoreg_MEM, o_valid_MEM, o_zero_EX
    );

endinterface

// File: rtl/alu.sv
// Combinational MIPS ALU. All arithmetic wraps modulo 2^DATA_W; shifts act on
// operand b by sh; unassigned opcodes yield zero.
module alu
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        sh,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves result unassigned (no latch).
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = DATA_W'($signed(a) < $signed(b));
            ALU_SLTU: result = DATA_W'(a < b);
            ALU_SLL:  result = b << sh;
            ALU_SRL:  result = b >> sh;
            ALU_SRA:  result = $signed(b) >>> sh;
            ALU_LUI:  result = DATA_W'(b[15:0]) << 16;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: resolves forwarded operands, runs the ALU and holds the
// EX/MEM pipeline register under reset > flush > stall priority.
module ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input logic       i_clk,
    input logic       i_reset,
    ex_stage_if.slave bus
);

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] fwd_rt;
    logic [DATA_W-1:0] op_b;
    logic [4:0]        sh;
    logic [DATA_W-1:0] alu_out;
    ctrl_t             ctrl_in;
    ctrl_t             ctrl_q;

    function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0]        sel,
                                                  input logic [DATA_W-1:0] id_val,
                                                  input logic [DATA_W-1:0] wb_val,
                                                  input logic [DATA_W-1:0] mem_val);
        case (sel)
            FWD_WB:  return wb_val;
            FWD_MEM: return mem_val;
            default: return id_val;
        endcase
    endfunction

    assign op_a   = fwd_mux(bus.i_forward_a, bus.i_rs_data_EX, bus.i_fwd_wb_data, bus.i_fwd_mem_data);
    assign fwd_rt = fwd_mux(bus.i_forward_b, bus.i_rt_data_EX, bus.i_fwd_wb_data, bus.i_fwd_mem_data);
    assign op_b   = bus.i_alu_src_EX ? bus.i_imm_EX : fwd_rt;
    assign sh     = bus.i_shift_var_EX ? op_a[4:0] : bus.i_shamt_EX;

    // Branch compare uses the register operands, not the immediate-selected B.
    assign bus.o_zero_EX = (op_a == fwd_rt);

    alu #(.DATA_W(DATA_W)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .sh     (sh),
        .op     (bus.i_alu_op_EX),
        .result (alu_out)
    );

    assign ctrl_in = '{regwrite: bus.i_regwrite_EX,
                       memread:  bus.i_memread_EX,
                       memwrite: bus.i_memwrite_EX,
                       memtoreg: bus.i_memtoreg_EX};

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every EX/MEM field samples pre-edge values together.
        if (i_reset || bus.i_flush) begin
            bus.o_alu_result_MEM <= '0;
            bus.o_store_data_MEM <= '0;
            bus.o_rd_MEM         <= '0;
            ctrl_q               <= '0;
            bus.o_valid_MEM      <= 1'b0;
        end else if (!bus.i_stall) begin
            bus.o_alu_result_MEM <= alu_out;
            bus.o_store_data_MEM <= fwd_rt;
            bus.o_rd_MEM         <= bus.i_rd_EX;
            ctrl_q               <= bus.i_valid_EX ? ctrl_in : '0;
            bus.o_valid_MEM      <= bus.i_valid_EX;
        end
    end

    assign bus.o_regwrite_MEM = ctrl_q.regwrite;
    assign bus.o_memread_MEM  = ctrl_q.memread;
    assign bus.o_memwrite_MEM = ctrl_q.memwrite;
    assign bus.o_memtoreg_MEM = ctrl_q.memtoreg;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, immediates, ALU corners, stall,
// flush, invalid bubbles and reset priority with hand-computed expectations.
module tb_ex_stage;
    import mips_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    ex_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

    ex_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.i_stall = 0;        bus.i_flush = 0;        bus.i_valid_EX = 0;
        bus.i_rs_data_EX = 0;   bus.i_rt_data_EX = 0;   bus.i_imm_EX = 0;
        bus.i_shamt_EX = 0;     bus.i_shift_var_EX = 0; bus.i_alu_op_EX = ALU_ADD;
        bus.i_alu_src_EX = 0;   bus.i_rd_EX = 0;        bus.i_regwrite_EX = 0;
        bus.i_memread_EX = 0;   bus.i_memwrite_EX = 0;  bus.i_memtoreg_EX = 0;
        bus.i_forward_a = FWD_ID; bus.i_forward_b = FWD_ID;
        bus.i_fwd_mem_data = 0; bus.i_fwd_wb_data = 0;
    endtask

    task automatic test_reset();
        logic [3:0] ctrl;
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            bus.i_valid_EX = 1; bus.i_rs_data_EX = $urandom(); bus.i_rt_data_EX = $urandom();
            bus.i_imm_EX = $urandom(); bus.i_rd_EX = 5'($urandom()); bus.i_alu_op_EX = 4'($urandom());
            bus.i_regwrite_EX = 1; bus.i_memread_EX = 1; bus.i_memwrite_EX = 1; bus.i_memtoreg_EX = 1;
            bus.i_forward_a = 2'($urandom()); bus.i_forward_b = 2'($urandom());
            bus.i_fwd_mem_data = $urandom(); bus.i_fwd_wb_data = $urandom();
            tick();
        end
        ctrl = {bus.o_regwrite_MEM, bus.o_memread_MEM, bus.o_memwrite_MEM, bus.o_memtoreg_MEM};
        n_checks++; if (bus.o_alu_result_MEM !== 32'h0) begin n_fail++; $display("FAIL reset_alu got %h want 0", bus.o_alu_result_MEM); end
        n_checks++; if (bus.o_store_data_MEM !== 32'h0) begin n_fail++; $display("FAIL reset_store got %h want 0", bus.o_store_data_MEM); end
        n_checks++; if (bus.o_rd_MEM !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %0d want 0", bus.o_rd_MEM); end
        n_checks++; if (ctrl !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl got %b want 0000", ctrl); end
        n_checks++; if (bus.o_valid_MEM !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.o_valid_MEM); end
        reset = 0;
        set_idle();
    endtask

    task automatic test_forwarding();
        set_idle();
        bus.i_valid_EX = 1; bus.i_regwrite_EX = 1; bus.i_rd_EX = 5'd3;
        bus.i_rs_data_EX = 5; bus.i_rt_data_EX = 11; bus.i_fwd_mem_data = 7; bus.i_fwd_wb_data = 9;
        bus.i_forward_a = FWD_MEM; bus.i_forward_b = FWD_WB; bus.i_alu_op_EX = ALU_ADD;
        tick();
        n_checks++; if (bus.o_alu_result_MEM !== 32'd16) begin n_fail++; $display("FAIL fwd_add got %0d want 16", bus.o_alu_result_MEM); end
        n_checks++; if (bus.o_store_data_MEM !== 32'd9) begin n_fail++; $display("FAIL fwd_store got %0d want 9", bus.o_store_data_MEM); end
        n_checks++; if (bus.o_rd_MEM !== 5'd3 || bus.o_valid_MEM !== 1'b1 || bus.o_regwrite_MEM !== 1'b1) begin
            n_fail++; $display("FAIL fwd_ctrl got rd=%0d v=%b rw=%b want rd=3 v=1 rw=1", bus.o_rd_MEM, bus.o_valid_MEM, bus.o_regwrite_MEM); end
        bus.i_forward_a = 2'b11;
        tick();
        n_checks++; if (bus.o_alu_result_MEM !== 32'd14) begin n_fail++; $display("FAIL fwd_sel11 got %0d want 14", bus.o_alu_result_MEM); end
    endtask

    task automatic test_imm_store();
        set_idle();
        bus.i_valid_EX = 1; bus.i_memwrite_EX = 1; bus.i_alu_src_EX = 1; bus.i_imm_EX = 32'hFFFF_FFFC;
        bus.i_rs_data_EX = 32'h100; bus.i_rt_data_EX = 32'h1; bus.i_fwd_mem_data = 32'hAB;
        bus.i_forward_b = FWD_MEM; bus.i_alu_op_EX = ALU_ADD;
        tick();
        n_checks++; if (bus.o_alu_result_MEM !== 32'hFC) begin n_fail++; $display("FAIL imm_alu got %h want fc", bus.o_alu_result_MEM); end
        n_checks++; if (bus.o_store_data_MEM !== 32'hAB) begin n_fail++; $display("FAIL imm_store got %h want ab", bus.o_store_data_MEM); end
        n_checks++; if (bus.o_memwrite_MEM !== 1'b1 || bus.o_regwrite_MEM !== 1'b0) begin
            n_fail++; $display("FAIL imm_ctrl got mw=%b rw=%b want mw=1 rw=0", bus.o_memwrite_MEM, bus.o_regwrite_MEM); end
    endtask

    task automatic test_alu_corners();
        // op, shift_var, alu_src, A(rs), B(rt), imm, shamt, expected
        logic [3:0]  ops  [10] = '{ALU_SLT, ALU_SLTU, ALU_SRA, ALU_SRL, ALU_LUI, ALU_ADD, ALU_SUB, ALU_NOR, ALU_SLL, 4'd13};
        logic        svar [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        logic        src  [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        logic [31:0] av   [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'd35, 32'h0, 32'h7FFF_FFFF, 32'd3, 32'h0, 32'h0, 32'h1234};
        logic [31:0] bv   [10] = '{32'd1, 32'd1, 32'h8000_0000, 32'h80, 32'h0, 32'd1, 32'd5, 32'h0, 32'd1, 32'h5678};
        logic [31:0] imm  [10] = '{0, 0, 0, 0, 32'h1234, 0, 0, 0, 0, 0};
        logic [4:0]  sam  [10] = '{0, 0, 5'd4, 5'd7, 0, 0, 0, 0, 5'd31, 0};
        logic [31:0] exp  [10] = '{32'd1, 32'd0, 32'hF800_0000, 32'h10, 32'h1234_0000, 32'h8000_0000,
                                   32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
        set_idle();
        bus.i_valid_EX = 1;
        for (int i = 0; i < 10; i++) begin
            bus.i_alu_op_EX = ops[i]; bus.i_shift_var_EX = svar[i]; bus.i_alu_src_EX = src[i];
            bus.i_rs_data_EX = av[i]; bus.i_rt_data_EX = bv[i]; bus.i_imm_EX = imm[i]; bus.i_shamt_EX = sam[i];
            tick();
            n_checks++; if (bus.o_alu_result_MEM !== exp[i]) begin
                n_fail++; $display("FAIL alu_vec%0d op=%0d got %h want %h", i, ops[i], bus.o_alu_result_MEM, exp[i]); end
        end
    endtask

    task automatic test_stall();
        set_idle();
        bus.i_valid_EX = 1; bus.i_regwrite_EX = 1; bus.i_rd_EX = 5'd7;
        bus.i_rs_data_EX = 10; bus.i_rt_data_EX = 20; bus.i_alu_op_EX = ALU_ADD;
        tick();
        n_checks++; if (bus.o_alu_result_MEM !== 32'd30) begin n_fail++; $display("FAIL stall_load got %0d want 30", bus.o_alu_result_MEM); end
        bus.i_stall = 1;
        for (int i = 0; i < 3; i++) begin
            bus.i_rs_data_EX = 32'h55; bus.i_rt_data_EX = 32'h55; bus.i_rd_EX = 5'(i + 1);
            bus.i_valid_EX = i[0]; bus.i_memwrite_EX = 1; bus.i_alu_op_EX = ALU_OR;
            #1;
            n_checks++; if (bus.o_zero_EX !== 1'b1) begin n_fail++; $display("FAIL zero_stall got %b want 1", bus.o_zero_EX); end
            tick();
            n_checks++; if (bus.o_alu_result_MEM !== 32'd30 || bus.o_rd_MEM !== 5'd7 || bus.o_store_data_MEM !== 32'd20 ||
                            bus.o_regwrite_MEM !== 1'b1 || bus.o_memwrite_MEM !== 1'b0 || bus.o_valid_MEM !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold%0d got alu=%0d rd=%0d st=%0d rw=%b mw=%b v=%b want 30 7 20 1 0 1", i,
                    bus.o_alu_result_MEM, bus.o_rd_MEM, bus.o_store_data_MEM, bus.o_regwrite_MEM, bus.o_memwrite_MEM, bus.o_valid_MEM); end
        end
        bus.i_rs_data_EX = 1; bus.i_rt_data_EX = 2; bus.i_fwd_wb_data = 32'h55; bus.i_fwd_mem_data = 32'h55;
        bus.i_forward_a = FWD_WB; bus.i_forward_b = FWD_MEM;
        #1;
        n_checks++; if (bus.o_zero_EX !== 1'b1) begin n_fail++; $display("FAIL zero_fwd got %b want 1", bus.o_zero_EX); end
        bus.i_fwd_mem_data = 32'h56;
        #1;
        n_checks++; if (bus.o_zero_EX !== 1'b0) begin n_fail++; $display("FAIL zero_ne got %b want 0", bus.o_zero_EX); end
    endtask

    task automatic test_flush();
        set_idle();
        bus.i_stall = 1; bus.i_flush = 1; bus.i_valid_EX = 1; bus.i_regwrite_EX = 1; bus.i_memwrite_EX = 1;
        bus.i_rd_EX = 5'd9; bus.i_rs_data_EX = 4; bus.i_rt_data_EX = 4;
        tick();
        n_checks++; if (bus.o_regwrite_MEM !== 1'b0 || bus.o_memwrite_MEM !== 1'b0 || bus.o_valid_MEM !== 1'b0) begin
            n_fail++; $display("FAIL flush_ctrl got rw=%b mw=%b v=%b want 0 0 0", bus.o_regwrite_MEM, bus.o_memwrite_MEM, bus.o_valid_MEM); end
        n_checks++; if (bus.o_rd_MEM !== 5'd0 || bus.o_alu_result_MEM !== 32'h0) begin
            n_fail++; $display("FAIL flush_data got rd=%0d alu=%h want 0 0", bus.o_rd_MEM, bus.o_alu_result_MEM); end
    endtask

    task automatic test_invalid_r0();
        set_idle();
        bus.i_valid_EX = 0; bus.i_regwrite_EX = 1; bus.i_memread_EX = 1; bus.i_rd_EX = 5'd4;
        tick();
        n_checks++; if (bus.o_regwrite_MEM !== 1'b0 || bus.o_memread_MEM !== 1'b0 || bus.o_valid_MEM !== 1'b0) begin
            n_fail++; $display("FAIL invalid got rw=%b mr=%b v=%b want 0 0 0", bus.o_regwrite_MEM, bus.o_memread_MEM, bus.o_valid_MEM); end
        bus.i_valid_EX = 1; bus.i_memread_EX = 0; bus.i_memtoreg_EX = 1; bus.i_rd_EX = 5'd0;
        tick();
        n_checks++; if (bus.o_rd_MEM !== 5'd0 || bus.o_regwrite_MEM !== 1'b1 || bus.o_memtoreg_MEM !== 1'b1) begin
            n_fail++; $display("FAIL rd_zero got rd=%0d rw=%b mtr=%b want 0 1 1", bus.o_rd_MEM, bus.o_regwrite_MEM, bus.o_memtoreg_MEM); end
    endtask

    task automatic test_reset_priority();
        set_idle();
        bus.i_valid_EX = 1; bus.i_regwrite_EX = 1; bus.i_rd_EX = 5'd12;
        bus.i_rs_data_EX = 100; bus.i_rt_data_EX = 1; bus.i_alu_op_EX = ALU_SUB;
        tick();
        reset = 1; bus.i_stall = 1;
        tick();
        n_checks++; if (bus.o_valid_MEM !== 1'b0 || bus.o_rd_MEM !== 5'd0 || bus.o_alu_result_MEM !== 32'h0) begin
            n_fail++; $display("FAIL rst_over_stall got v=%b rd=%0d alu=%h want 0 0 0", bus.o_valid_MEM, bus.o_rd_MEM, bus.o_alu_result_MEM); end
        reset = 0;
        tick();
        n_checks++; if (bus.o_valid_MEM !== 1'b0 || bus.o_alu_result_MEM !== 32'h0) begin
            n_fail++; $display("FAIL rst_then_stall got v=%b alu=%h want 0 0", bus.o_valid_MEM, bus.o_alu_result_MEM); end
        bus.i_stall = 0;
        tick();
        n_checks++; if (bus.o_valid_MEM !== 1'b1 || bus.o_alu_result_MEM !== 32'd99 || bus.o_rd_MEM !== 5'd12) begin
            n_fail++; $display("FAIL first_capture got v=%b alu=%0d rd=%0d want 1 99 12", bus.o_valid_MEM, bus.o_alu_result_MEM, bus.o_rd_MEM); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1;
        set_idle();
        test_reset();
        test_forwarding();
        test_imm_store();
        test_alu_corners();
        test_stall();
        test_flush();
        test_invalid_r0();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline: consumes the ID/EX operands and the forwarding selects produced by the forwarding logic, and resolves operands A and B against the MEM and WB results.
- Computes the ALU result.
- Holds the EX/MEM pipeline register that feeds the memory stage, with stall and flush control driven by the hazard logic.

Parameters:
- DATA_W, 32, datapath width.
- REG_ADDR_W, 5, register-number width.

Ports:
- i_clk  in  1  clock; one clock domain, all state updates on its rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_stall  in  1  hold the EX/MEM register.
- i_flush  in  1  insert a bubble into EX/MEM.
- i_valid_EX  in  1  ID/EX holds a real instruction.
- i_rs_data_EX  in  DATA_W  rs value read in ID.
- i_rt_data_EX  in  DATA_W  rt value read in ID.
- i_imm_EX  in  DATA_W  sign/zero-extended immediate.
- i_shamt_EX  in  5  shift amount.
- i_shift_var_EX  in  1  1: shift amount = operand A[4:0].
- i_alu_op_EX  in  4  ALU operation.
- i_alu_src_EX  in  1  1: B = immediate.
- i_rd_EX  in  REG_ADDR_W  destination register, already resolved in ID.
- i_regwrite_EX, i_memread_EX, i_memwrite_EX, i_memtoreg_EX  in  1 each  control bits.
- i_forward_a, i_forward_b  in  2 each  00 = ID value, 01 = WB value, 10 = MEM value, 11 = same as 00.
- i_fwd_mem_data  in  DATA_W  ALU result currently in EX/MEM.
- i_fwd_wb_data  in  DATA_W  value being written back.
- o_alu_result_MEM  out  DATA_W  registered ALU result.
- o_store_data_MEM  out  DATA_W  registered forwarded rt, used by stores.
- o_rd_MEM  out  REG_ADDR_W  registered destination register.
- o_regwrite_MEM, o_memread_MEM, o_memwrite_MEM, o_memtoreg_MEM  out  1 each  registered controls.
- o_valid_MEM  out  1  EX/MEM holds a real instruction.
- o_zero_EX  out  1  combinational: forwarded A == forwarded B, for branch resolution.

Behaviour:
- Operand A = mux(i_forward_a) over {ID rs, WB, MEM}.
- fwd_rt = mux(i_forward_b) over {ID rt, WB, MEM}.
- Operand B = i_alu_src_EX ? i_imm_EX : fwd_rt.
- o_store_data_MEM always captures fwd_rt, never the immediate.
- ALU ops, all with modulo-2^DATA_W wrap and no overflow trap:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed, result 0/1), 7 SLTU (unsigned, result 0/1).
  - 8 SLL, 9 SRL, 10 SRA: shift B by sh, where sh = i_shift_var_EX ? A[4:0] : i_shamt_EX.
  - 11 LUI: B[15:0] << 16.
  - 12..15 produce 0.
- Latency: 1 cycle from EX inputs to the *_MEM outputs. The ALU itself is combinational.
- Register update priority at each rising edge of i_clk:
  1. i_reset: all *_MEM outputs = 0, o_valid_MEM = 0.
  2. i_flush: bubble. Controls, o_valid_MEM and o_rd_MEM = 0. Data outputs = 0. Flush wins over stall.
  3. i_stall: every *_MEM output holds its value.
  4. Otherwise capture new values. If i_valid_EX = 0, controls and o_valid_MEM load 0, so no write side effects.
- Reset mid-stall or mid-flush: reset wins. The first capture occurs on the first edge with i_reset = 0 and i_stall = 0.
- Writes to $0: the stage passes rd = 0 and regwrite unchanged; suppression is downstream.
- o_zero_EX is purely combinational and unaffected by stall or flush.

Decomposition:
- Package mips_pkg holds:
  - ALU opcode localparams (ALU_ADD..ALU_LUI).
  - Forward-select localparams (FWD_ID = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10).
  - DATA_W and REG_ADDR_W defaults.
- One sub-module: alu, combinational; inputs A, B, sh, op; output result.
- Operand muxes and the EX/MEM register stay in ex_stage.

Test Plan:
- Reset: hold i_reset with random inputs for 2 cycles -> all *_MEM outputs = 0, including o_valid_MEM.
- Forwarding:
  - rs_data = 5, MEM = 7, WB = 9, forward_a = 10, forward_b = 01, alu_op ADD, alu_src = 0 -> next cycle alu_result = 16, store_data = 9.
  - forward_a = 11 -> A = 5.
- Immediate/store: alu_src = 1, imm = 0xFFFFFFFC, rs = 0x100, rt forwarded = 0xAB, memwrite = 1 -> alu_result = 0xFC, store_data = 0xAB, memwrite_MEM = 1.
- ALU corners:
  - SLT A = 0xFFFFFFFF, B = 1 -> 1; SLTU on the same operands -> 0.
  - SRA 0x80000000 by shamt 4 -> 0xF8000000.
  - SRL with shift_var = 1, A = 35 (sh = 3), B = 0x80 -> 0x10.
  - LUI imm = 0x1234 -> 0x12340000.
  - ADD 0x7FFFFFFF + 1 -> 0x80000000 with no trap.
- Stall/flush:
  - Load instr X, then hold i_stall = 1 for 3 cycles while changing inputs -> outputs stay X.
  - Assert i_stall = 1 and i_flush = 1 together -> bubble: regwrite = memwrite = valid = 0.
- Invalid and $0:
  - i_valid_EX = 0 with regwrite = 1 -> regwrite_MEM = 0.
  - Valid instr with rd = 0, regwrite = 1 -> o_rd_MEM = 0, regwrite_MEM = 1.
  - o_zero_EX = 1 when forwarded A = B = 0x55, including during a stall.
